mac_dot_accum: RTL and testbench

//  Streaming signed dot-product engine; successor to the fixed 16x16 accumulate wrapper.

---
 rtl/mac_dot_accum.sv | 168 ++++++++++++++++
 tb/tb_mac_dot_accum.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_accum.sv
// Streaming signed dot-product engine.
// Takes LEN (a,b) beats over a valid/ready input and sums the signed products.
// It then presents one saturated or truncated result on a valid/ready output
// and clears itself for the next vector.
module mac_dot_accum #(
  parameter int DATA_W   = 16,
  parameter int LEN_W    = 8,
  parameter int ACC_W    = 40,
  parameter int OUT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  result,
  output logic                     sat,
  output logic                     busy
);

  // The accumulator must hold a full-length sum of worst-case products without wrapping
  if (ACC_W < 2*DATA_W + LEN_W) begin : g_acc_w_check
    $error("mac_dot_accum: ACC_W must be >= 2*DATA_W+LEN_W");
  end
  if (OUT_W > ACC_W) begin : g_out_w_check
    $error("mac_dot_accum: OUT_W must be <= ACC_W");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  // Signed output range expressed at accumulator width for clamping
  localparam logic signed [ACC_W-1:0] MAX_OUT = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_OUT = ~MAX_OUT;

  state_t                     state, next_state;
  logic                       can_accept, accept, len_short;
  logic [LEN_W-1:0]           len_q, count, next_count;
  logic [1:0]                 drain_cnt;
  logic                       s1_valid, s2_valid;
  logic signed [DATA_W-1:0]   s1_a, s1_b;
  logic signed [2*DATA_W-1:0] a_ext, b_ext, prod_full, s2_prod;
  logic signed [ACC_W-1:0]    acc, prod_ext;
  logic signed [OUT_W-1:0]    sat_result, result_q;
  logic                       sat_flag, sat_q;

  assign next_count = count + 1'b1;
  assign len_short  = (len == '0) || (len == LEN_W'(1));
  assign accept     = in_valid & in_ready;

  // The multiply is done at double width so the most-negative corner product stays exact
  assign a_ext     = {{DATA_W{s1_a[DATA_W-1]}}, s1_a};
  assign b_ext     = {{DATA_W{s1_b[DATA_W-1]}}, s1_b};
  assign prod_full = a_ext * b_ext;
  assign prod_ext  = {{(ACC_W-2*DATA_W){s2_prod[2*DATA_W-1]}}, s2_prod};

  // All outputs are forced to their idle values while reset is high
  assign in_ready  = can_accept & ~rst;
  assign out_valid = (state == OUT) & ~rst;
  assign busy      = (state != IDLE) & ~rst;
  assign result    = rst ? '0 : result_q;
  assign sat       = sat_q & ~rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; the drain stays three cycles so the final product has reached the accumulator and the result register
  always_comb begin
    next_state = state;
    can_accept = 1'b0;
    case (state)
      IDLE: begin
        can_accept = 1'b1;
        if (in_valid) next_state = len_short ? DRAIN : ACCUM;
      end
      ACCUM: begin
        can_accept = 1'b1;
        if (in_valid && next_count == len_q) next_state = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == 2'd2) next_state = OUT;
      end
      OUT: begin
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Vector length capture and beat counting; len is only sampled on the first beat
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      count     <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        if (state == IDLE) begin
          len_q <= (len == '0) ? LEN_W'(1) : len;
          count <= LEN_W'(1);
        end else begin
          count <= next_count;
        end
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
      else                drain_cnt <= '0;
    end
  end

  // Operand, product and accumulate pipeline; bubbles carry no valid and add nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_prod  <= '0;
      acc      <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a <= a_in;
        s1_b <= b_in;
      end
      s2_valid <= s1_valid;
      if (s1_valid) s2_prod <= prod_full;
      if (state == OUT && out_ready) acc <= '0;
      else if (s2_valid)             acc <= acc + prod_ext;
    end
  end

  // Clamp or truncate the accumulator to the output width
  always_comb begin
    sat_result = acc[OUT_W-1:0];
    sat_flag   = 1'b0;
    if (SATURATE) begin
      if (acc > MAX_OUT) begin
        sat_result = MAX_OUT[OUT_W-1:0];
        sat_flag   = 1'b1;
      end else if (acc < MIN_OUT) begin
        sat_result = MIN_OUT[OUT_W-1:0];
        sat_flag   = 1'b1;
      end
    end
  end

  // Result register, loaded as the drain ends and cleared when the result is handed off
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      sat_q    <= 1'b0;
    end else if (state == DRAIN && drain_cnt == 2'd2) begin
      result_q <= sat_result;
      sat_q    <= sat_flag;
    end else if (state == OUT && out_ready) begin
      result_q <= '0;
      sat_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_dot_accum.sv
// Testbench for mac_dot_accum.
// A saturating and a truncating instance share the same stimulus.
// Expected results come from a plain-arithmetic dot-product model and are queued
// per vector; a monitor pops and compares them on every output handoff.
module tb_mac_dot_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, in_valid, out_ready;
  logic        [7:0]  len;
  logic signed [15:0] a_in, b_in;
  logic               in_ready, out_valid, sat, busy;
  logic signed [31:0] result;
  logic               in_ready_t, out_valid_t, sat_t, busy_t;
  logic signed [31:0] result_t;

  mac_dot_accum #(.DATA_W(16), .LEN_W(8), .ACC_W(40), .OUT_W(32), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .len(len), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .sat(sat), .busy(busy)
  );

  mac_dot_accum #(.DATA_W(16), .LEN_W(8), .ACC_W(40), .OUT_W(32), .SATURATE(1'b0)) dut_trunc (
    .clk(clk), .rst(rst), .len(len), .in_valid(in_valid), .in_ready(in_ready_t),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid_t), .out_ready(out_ready),
    .result(result_t), .sat(sat_t), .busy(busy_t)
  );

  typedef struct {
    int res_sat;
    bit flag_sat;
    int res_trunc;
  } exp_t;

  exp_t sb[$];
  int   vec_a[$];
  int   vec_b[$];
  int   checks = 0;
  int   failures = 0;
  bit   rand_ready_mode = 1'b0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Dot product over the beats in vec_a/vec_b, then clamped and truncated views of the sum
  function automatic exp_t modelVector();
    exp_t        e;
    longint      sum = 0;
    logic [63:0] bits;
    foreach (vec_a[i]) sum += longint'(vec_a[i]) * longint'(vec_b[i]);
    bits        = sum;
    e.res_trunc = int'(bits[31:0]);
    if (sum > 64'sd2147483647) begin
      e.res_sat  = 32'h7FFF_FFFF;
      e.flag_sat = 1'b1;
    end else if (sum < -64'sd2147483648) begin
      e.res_sat  = 32'h8000_0000;
      e.flag_sat = 1'b1;
    end else begin
      e.res_sat  = int'(sum);
      e.flag_sat = 1'b0;
    end
    return e;
  endfunction

  // Present one beat and hold it until the DUT accepts it; called just after a rising edge
  task automatic driveBeat(input logic [7:0] len_v, input int a, input int b);
    int waited = 0;
    in_valid = 1'b1;
    len      = len_v;
    a_in     = a[15:0];
    b_in     = b[15:0];
    @(negedge clk);
    while (!in_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Queue the expected response, then drive the whole vector with optional bubbles and len toggling
  task automatic applyStimulus(input int len_v, input bit bubbles, input bit toggle_len);
    logic [7:0] lv;
    sb.push_back(modelVector());
    foreach (vec_a[i]) begin
      if (bubbles && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      lv = (toggle_len && i > 0) ? 8'($urandom_range(0, 255)) : len_v[7:0];
      driveBeat(lv, vec_a[i], vec_b[i]);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare both instances on every cycle a result is handed off
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("result_sat", result, e.res_sat);
          checkOutput("sat_flag", sat, e.flag_sat);
          checkOutput("trunc_valid", out_valid_t, 1);
          checkOutput("result_trunc", result_t, e.res_trunc);
          checkOutput("trunc_sat_flag", sat_t, 0);
        end
      end
    end
  end

  // Random downstream back-pressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; len = '0; a_in = '0; b_in = '0; out_ready = 1'b1;

    // Reset state, observed while reset is held
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_sat", sat, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", in_ready, 1);
    checkOutput("idle_busy", busy, 0);
    @(posedge clk);
    #1;

    // Back-to-back vector, latency and single-cycle handoff
    vec_a = '{1, 2, 3, 4};
    vec_b = '{5, 6, 7, 8};
    applyStimulus(4, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) checkOutput("t1_drain_in_ready", in_ready, 0);
    end while (!out_valid && n < 20);
    checkOutput("t1_latency", n, 4);
    checkOutput("t1_result", result, 70);
    @(negedge clk);
    checkOutput("t1_single_cycle", out_valid, 0);
    checkOutput("t1_in_ready_next", in_ready, 1);
    @(posedge clk);
    #1;

    // Bubbles and the most-negative corner product
    vec_a = '{-3, 100, -32768};
    vec_b = '{7, -2, -32768};
    applyStimulus(3, 1'b1, 1'b0);
    waitDrain();

    // Full-length vector of corner products: clamps on one instance, wraps on the other
    vec_a = {};
    vec_b = {};
    for (int i = 0; i < 255; i++) begin
      vec_a.push_back(-32768);
      vec_b.push_back(-32768);
    end
    applyStimulus(255, 1'b0, 1'b0);
    waitDrain();

    // Output held under back-pressure
    out_ready = 1'b0;
    vec_a = '{3, 5};
    vec_b = '{-4, 6};
    applyStimulus(2, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("t4_hold_valid", out_valid, 1);
      checkOutput("t4_hold_result", result, 18);
      checkOutput("t4_hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t4_back_idle", busy, 0);
    @(posedge clk);
    #1;
    vec_a = '{7};
    vec_b = '{7};
    applyStimulus(1, 1'b0, 1'b0);
    waitDrain();

    // Reset in the middle of a vector
    driveBeat(8'd5, 11, 12);
    driveBeat(8'd5, 13, 14);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_out_valid", out_valid, 0);
    checkOutput("t5_rst_in_ready", in_ready, 0);
    checkOutput("t5_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    vec_a = '{9};
    vec_b = '{-9};
    applyStimulus(1, 1'b0, 1'b0);
    waitDrain();

    // Zero length counts as one beat; len changes after the first beat are ignored
    vec_a = '{5};
    vec_b = '{6};
    applyStimulus(0, 1'b0, 1'b0);
    waitDrain();
    vec_a = '{-200, 3000, 17};
    vec_b = '{45, -6, 32767};
    applyStimulus(3, 1'b0, 1'b1);
    waitDrain();

    // Randomized vectors with bubbles and random back-pressure
    rand_ready_mode = 1'b1;
    for (int v = 0; v < 25; v++) begin
      int lv;
      lv = $urandom_range(0, 10);
      vec_a = {};
      vec_b = {};
      for (int i = 0; i < ((lv == 0) ? 1 : lv); i++) begin
        vec_a.push_back(int'($urandom_range(0, 65535)) - 32768);
        vec_b.push_back(int'($urandom_range(0, 65535)) - 32768);
      end
      applyStimulus(lv, 1'b1, 1'($urandom_range(0, 1)));
    end
    rand_ready_mode = 1'b0;
    out_ready = 1'b1;
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
